// File: rtl/mips_pkg.sv
// Shared MIPS funct encodings, HI/LO divider FSM states and small helpers.
package mips_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MTLO  = 6'b010011;
    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV   = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    function automatic logic is_hilo_op(input logic [5:0] funct);
        return funct inside {MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU};
    endfunction

    // Magnitude of a two's complement value when treated as signed.
    function automatic logic [DATA_W-1:0] abs_if(input logic [DATA_W-1:0] v, input logic sgn);
        return (sgn && v[DATA_W-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/hilo_div_unit_div_core.sv
// Unsigned restoring divider datapath: one remainder/quotient step per step_en.
module div_core
    import mips_pkg::*;
#(
    parameter int unsigned ITERS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              step_en_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o,
    output logic              last_o
);

    localparam int unsigned CW = $clog2(ITERS);

    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] dvsr_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W:0]   shifted;
    logic              ge;

    // The quotient register doubles as the dividend shift source.
    always_comb begin
        shifted = {rem_q, quot_q[DATA_W-1]};
        ge      = (shifted >= {1'b0, dvsr_q});
        rem_d   = ge ? (shifted[DATA_W-1:0] - dvsr_q) : shifted[DATA_W-1:0];
        quot_d  = {quot_q[DATA_W-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
        end else if (start_i) begin
            rem_q  <= '0;
            quot_q <= dividend_i;
            dvsr_q <= divisor_i;
            cnt_q  <= '0;
        end else if (step_en_i) begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;
    assign last_o      = (cnt_q == CW'(ITERS - 1));

endmodule

// File: rtl/hilo_div_unit.sv
// HI/LO register owner: MULT capture, MTHI/MTLO, MFHI/MFLO reads, iterative DIV/DIVU.
// Optional HILO_DIV_ZERO_FAST_EN: zero divisor bypasses the iteration phase.
module hilo_div_unit
    import mips_pkg::*;
#(
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [5:0]        op_sel,
    input  logic [DATA_W-1:0] input1,
    input  logic [DATA_W-1:0] input2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] alu_result_h,
    input  logic              flush,
    output logic              stall_req,
    output logic              busy,
    output logic [DATA_W-1:0] mf_data,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    div_state_t        state_q, state_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic              qneg_q, rneg_q, dz_q;
    logic              accept, is_div, sgn, start, step_en, last;
    logic [DATA_W-1:0] quot_w, rem_w, q_res, r_res;

    assign accept  = op_valid && (state_q == IDLE) && !flush;
    assign is_div  = (op_sel == DIV) || (op_sel == DIVU);
    assign sgn     = (op_sel == DIV);
    assign start   = accept && is_div;
    assign step_en = (state_q == ITER) && !flush;

    div_core #(.ITERS(DIV_ITERS)) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .step_en_i   (step_en),
        .dividend_i  (abs_if(input1, sgn)),
        .divisor_i   (abs_if(input2, sgn)),
        .quotient_o  (quot_w),
        .remainder_o (rem_w),
        .last_o      (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) begin
`ifdef HILO_DIV_ZERO_FAST_EN
                state_d = (input2 == '0) ? FIX : ITER;
`else
                state_d = ITER;
`endif
            end
            ITER: if (flush) state_d = IDLE;
                  else if (last) state_d = FIX;
            default: state_d = IDLE;
        endcase
    end

    // Zero divisor keeps the raw unsigned result; with the fast path no shifts
    // happened, so the dividend magnitude still sits in the quotient register.
    always_comb begin
`ifdef HILO_DIV_ZERO_FAST_EN
        q_res = dz_q ? '1     : (qneg_q ? -quot_w : quot_w);
        r_res = dz_q ? quot_w : (rneg_q ? -rem_w  : rem_w);
`else
        q_res = dz_q ? quot_w : (qneg_q ? -quot_w : quot_w);
        r_res = dz_q ? rem_w  : (rneg_q ? -rem_w  : rem_w);
`endif
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (accept) begin
            case (op_sel)
                MULT, MULTU: begin
                    hi_d = alu_result_h;
                    lo_d = alu_result;
                end
                MTHI:    hi_d = input1;
                MTLO:    lo_d = input1;
                default: ;
            endcase
        end
        if ((state_q == FIX) && !flush) begin
            hi_d = r_res;
            lo_d = q_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (start) begin
                qneg_q <= sgn && (input1[DATA_W-1] ^ input2[DATA_W-1]);
                rneg_q <= sgn && input1[DATA_W-1];
                dz_q   <= (input2 == '0);
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign stall_req = busy && op_valid && is_hilo_op(op_sel);
    assign hi        = hi_q;
    assign lo        = lo_q;

    always_comb begin
        mf_data = '0;
        if (op_valid && (op_sel == MFHI)) mf_data = hi_q;
        else if (op_valid && (op_sel == MFLO)) mf_data = lo_q;
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Scoreboard bench for hilo_div_unit: random and directed HI/LO ops vs. an arithmetic model.
module tb_hilo_div_unit;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADDU  = 6'b100001;

`ifdef HILO_DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, op_valid, flush;
    logic [5:0]  op_sel;
    logic [31:0] input1, input2, alu_result, alu_result_h;
    logic        stall_req, busy;
    logic [31:0] mf_data, hi, lo;

    hilo_div_unit #(.DIV_ITERS(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_valid     (op_valid),
        .op_sel       (op_sel),
        .input1       (input1),
        .input2       (input2),
        .alu_result   (alu_result),
        .alu_result_h (alu_result_h),
        .flush        (flush),
        .stall_req    (stall_req),
        .busy         (busy),
        .mf_data      (mf_data),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Reference: plain arithmetic, with the zero-divisor and overflow rules.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic [31:0] q, r;
        int sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = (sgn && a[31]) ? (32'd0 - a) : a;
        end else if (sgn) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                q = 32'h80000000;
                r = 32'd0;
            end else begin
                sa = $signed(a);
                sb = $signed(b);
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Monitor: pops on single-cycle writes and on every busy falling edge.
    logic wr_pend   = 1'b0;
    logic prev_busy = 1'b0;

    always @(posedge clk)
        wr_pend <= rst_n && op_valid && !busy && !flush &&
                   (op_sel inside {F_MULT, F_MULTU, F_MTHI, F_MTLO});

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy <= 1'b0;
        end else begin
            if (wr_pend || (prev_busy && !busy)) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL scoreboard_underflow: got hi=%h lo=%h with no expectation", hi, lo);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check(e.name, {hi, lo}, {e.hi, e.lo});
                end
            end
            prev_busy <= busy;
        end
    end

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] rh, input logic [31:0] rl);
        @(negedge clk); #1;
        op_valid = 1'b1; op_sel = f; input1 = a; input2 = b;
        alu_result_h = rh; alu_result = rl;
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic single(input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] rh, input logic [31:0] rl, input string name);
        case (f)
            F_MTHI:  m_hi = a;
            F_MTLO:  m_lo = a;
            default: begin m_hi = rh; m_lo = rl; end
        endcase
        exp_q.push_back('{name, m_hi, m_lo});
        issue(f, a, 32'h0, rh, rl);
    endtask

    task automatic mf_check(input string name);
        @(negedge clk); #1;
        op_valid = 1'b1; op_sel = F_MFLO; #1;
        check({name, "_mflo"}, mf_data, m_lo);
        op_sel = F_MFHI; #1;
        check({name, "_mfhi"}, mf_data, m_hi);
        op_valid = 1'b0;
    endtask

    // mode 0: plain, 1: MFHI/ADDU stall probe, 2: flush at cycle 20, 3: reset at cycle 15
    task automatic do_div(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int mode, input string name);
        logic [63:0] r;
        int          cycles;
        bit          done;
        r = ref_div(a, b, f == F_DIV);
        if (mode == 2) begin
            exp_q.push_back('{name, m_hi, m_lo});
        end else if (mode != 3) begin
            m_hi = r[63:32];
            m_lo = r[31:0];
            exp_q.push_back('{name, m_hi, m_lo});
        end
        issue(f, a, b, 32'h0, 32'h0);
        cycles = 0;
        done   = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (!busy) begin done = 1'b1; break; end
            cycles++;
            #1;
            if (mode == 1) begin
                if (k == 10 || k == 17) begin op_valid = 1'b1; op_sel = F_MFHI; end
                if (k == 11) check({name, "_stall_mfhi"}, stall_req, 1'b1);
                if (k == 15) op_sel = F_ADDU;
                if (k == 16) check({name, "_nostall_addu"}, stall_req, 1'b0);
                if (k == 33) check({name, "_stall_fix"}, stall_req, 1'b1);
            end else if (mode == 2 && k == 20) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
            end else if (mode == 3 && k == 15) begin
                rst_n = 1'b0; #1;
                check({name, "_reset_outputs"}, {hi, lo, mf_data, busy, stall_req}, '0);
                exp_q.delete();
                m_hi = '0;
                m_lo = '0;
                @(negedge clk); #2;
                rst_n = 1'b1;
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_total++;
            $display("FAIL %s_timeout: busy still %b after 100 cycles, required 0", name, busy);
        end else if (mode == 0 || mode == 1) begin
            check({name, "_busy_cycles"}, cycles, (FAST && b == 32'd0) ? 1 : 33);
        end else if (mode == 2) begin
            check({name, "_busy_cycles"}, cycles, 20);
        end
        if (mode == 1) begin
            #1;
            check({name, "_stall_released"}, stall_req, 1'b0);
            check({name, "_mfhi_after"}, mf_data, m_hi);
            op_valid = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; flush = 1'b0; op_sel = '0;
        input1 = '0; input2 = '0; alu_result = '0; alu_result_h = '0;
        #2;
        check("reset_state", {hi, lo, mf_data, busy, stall_req}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        single(F_MULTU, 32'h0, 32'h00000001, 32'hFFFFFFFE, "multu_first");
        mf_check("multu_first");

        do_div(F_DIVU, 32'd100, 32'd7, 0, "divu_100_7");
        do_div(F_DIV, 32'hFFFFFFF9, 32'd2, 0, "div_m7_2");
        do_div(F_DIV, 32'h80000000, 32'hFFFFFFFF, 0, "div_overflow");
        do_div(F_DIVU, 32'd5, 32'd0, 0, "divu_5_0");
        do_div(F_DIV, 32'hFFFFFFF7, 32'd0, 0, "div_m9_0");
        mf_check("after_div0");
        do_div(F_DIV, 32'h12345678, 32'hFFFFFFFD, 1, "div_stall");
        do_div(F_DIVU, 32'd1000, 32'd3, 2, "divu_flush");
        mf_check("after_flush");

        for (int i = 0; i < 25; i++) begin
            logic [31:0] a, b, rh, rl;
            int unsigned kind;
            kind = $urandom_range(0, 5);
            a  = $urandom;
            rh = $urandom;
            rl = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(1, 15);
                1:       b = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
                default: b = $urandom;
            endcase
            case (kind)
                0: single(F_MULT,  a, rh, rl, "rnd_mult");
                1: single(F_MULTU, a, rh, rl, "rnd_multu");
                2: single(F_MTHI,  a, rh, rl, "rnd_mthi");
                3: single(F_MTLO,  a, rh, rl, "rnd_mtlo");
                4: do_div(F_DIV,  a, b, 0, "rnd_div");
                default: do_div(F_DIVU, a, b, 0, "rnd_divu");
            endcase
            mf_check("rnd");
        end

        do_div(F_DIVU, 32'hDEADBEEF, 32'd17, 3, "divu_reset");
        mf_check("after_reset");
        single(F_MTHI, 32'hCAFEF00D, 32'h0, 32'h0, "mthi_after_reset");
        mf_check("mthi_after_reset");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
